// File: rtl/cram_responder_pkg.sv
// Shared FSM encoding and BCR field layout for the Pocket cellular RAM
// responder (cram_responder and its per-die storage).
package cram_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    READ_WAIT,
    READ_DRIVE,
    WRITE
  } cram_resp_state_e;

  localparam int CRAM_BCR_LAT_LSB = 11;
  localparam int CRAM_BCR_LAT_W   = 3;

  // A zero latency field in the BCR falls back to the build-time default.
  function automatic logic [CRAM_BCR_LAT_W-1:0] cram_eff_latency(
    input logic [15:0]               bcr_val,
    input logic [CRAM_BCR_LAT_W-1:0] dflt
  );
    logic [CRAM_BCR_LAT_W-1:0] field;
    field = bcr_val[CRAM_BCR_LAT_LSB +: CRAM_BCR_LAT_W];
    return (field != '0) ? field : dflt;
  endfunction

endpackage

// File: rtl/cram_responder_mem.sv
// One CRAM die: 2**ADDR_W x 16 single-port storage with per-byte write
// enables and an asynchronous read port. Contents are never reset.
module cram_responder_mem
  import cram_responder_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [1:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      if (be[1]) mem[addr][15:8] <= wdata[15:8];
      if (be[0]) mem[addr][7:0]  <= wdata[7:0];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/cram_responder.sv
// Device-side model of the Pocket cellular RAM (two dies, async, A/D muxed).
// Define CRAM_RESPONDER_BCR_EN to make cre=1 writes load a live BCR.
module cram_responder
  import cram_responder_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int READ_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  input  logic [5:0]  a,
  input  logic        adv_n,
  input  logic        cre,
  input  logic        ce0_n,
  input  logic        ce1_n,
  input  logic        oe_n,
  input  logic        we_n,
  input  logic        ub_n,
  input  logic        lb_n,
  output logic        wait_out,
  output logic        protocol_err,
  output logic [15:0] bcr
);

  localparam logic [2:0] DFLT_LAT = 3'(READ_LATENCY);

  cram_resp_state_e state_q, state_d;
  logic [21:0] addr_q, addr_d;
  logic        die_q, die_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d;
  logic        wait_q, wait_d;
  logic        perr_q, perr_d;
  logic        mem_we, bcr_wr;
  logic [15:0] rdata0, rdata1, rdata, bcr_cur;
  logic [2:0]  eff_lat;
  logic        sel_ce_n, both_ce, rw_clash;
  logic        unused_bits;

  assign sel_ce_n = die_q ? ce1_n : ce0_n;
  assign both_ce  = ~ce0_n & ~ce1_n;
  assign rw_clash = ~oe_n & ~we_n;
  assign rdata    = die_q ? rdata1 : rdata0;
  assign eff_lat  = cram_eff_latency(bcr_cur, DFLT_LAT);

  // Abort conditions outrank the per-state behaviour in every active state.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    die_d    = die_q;
    cnt_d    = cnt_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    dq_out_d = dq_out_q;
    dq_oe_d  = 1'b0;
    wait_d   = 1'b0;
    perr_d   = 1'b0;
    mem_we   = 1'b0;
    bcr_wr   = 1'b0;
    if (state_q == IDLE) begin
      if (both_ce) begin
        perr_d = 1'b1;
      end else if ((~ce0_n | ~ce1_n) & ~adv_n) begin
        state_d = ADDR;
        die_d   = ~ce1_n;
        addr_d  = {a, dq_in};
      end
    end else if (both_ce) begin
      perr_d  = 1'b1;
      state_d = IDLE;
    end else if (sel_ce_n) begin
      state_d = IDLE;
    end else if (rw_clash) begin
      perr_d  = 1'b1;
      state_d = ADDR;
    end else begin
      case (state_q)
        ADDR: begin
          if (!adv_n) addr_d = {a, dq_in};
          if (!oe_n) begin
            state_d = READ_WAIT;
            cnt_d   = eff_lat - 3'd1;
            wait_d  = 1'b1;
          end else if (!we_n) begin
            state_d = WRITE;
            wdata_d = dq_in;
            be_d    = {~ub_n, ~lb_n};
          end
        end
        READ_WAIT: begin
          if (oe_n) begin
            state_d = ADDR;
          end else if (cnt_q == 3'd0) begin
            state_d  = READ_DRIVE;
            dq_oe_d  = 1'b1;
            dq_out_d = rdata;
          end else begin
            cnt_d  = cnt_q - 3'd1;
            wait_d = 1'b1;
          end
        end
        READ_DRIVE: begin
          if (!adv_n) addr_d = {a, dq_in};
          if (oe_n) begin
            state_d = ADDR;
          end else begin
            dq_oe_d  = 1'b1;
            dq_out_d = rdata;
          end
        end
        WRITE: begin
          if (!we_n) begin
            wdata_d = dq_in;
            be_d    = {~ub_n, ~lb_n};
          end else begin
            state_d = ADDR;
            if (cre) begin
              bcr_wr = 1'b1;
`ifndef CRAM_RESPONDER_BCR_EN
              perr_d = 1'b1;
`endif
            end else begin
              mem_we = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      die_q    <= 1'b0;
      cnt_q    <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
      wait_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      die_q    <= die_d;
      cnt_q    <= cnt_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
      wait_q   <= wait_d;
      perr_q   <= perr_d;
    end
  end

`ifdef CRAM_RESPONDER_BCR_EN
  logic [15:0] bcr_q, bcr_d;

  assign bcr_d = bcr_wr ? addr_q[15:0] : bcr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bcr_q <= '0;
    else          bcr_q <= bcr_d;
  end

  assign bcr_cur     = bcr_q;
  assign unused_bits = ^addr_q;
`else
  assign bcr_cur     = 16'h0000;
  assign unused_bits = ^{addr_q, bcr_wr};
`endif

  cram_responder_mem #(.ADDR_W(ADDR_W)) u_die0 (
    .clk   (clk),
    .we    (mem_we & ~die_q),
    .be    (be_q),
    .addr  (addr_q[ADDR_W-1:0]),
    .wdata (wdata_q),
    .rdata (rdata0)
  );

  cram_responder_mem #(.ADDR_W(ADDR_W)) u_die1 (
    .clk   (clk),
    .we    (mem_we & die_q),
    .be    (be_q),
    .addr  (addr_q[ADDR_W-1:0]),
    .wdata (wdata_q),
    .rdata (rdata1)
  );

  assign dq_out       = dq_out_q;
  assign dq_oe        = dq_oe_q;
  assign wait_out     = wait_q;
  assign protocol_err = perr_q;
  assign bcr          = bcr_cur;

endmodule

// File: tb/tb_cram_responder.sv
// Self-checking bench for cram_responder: a transaction-level memory/timeline
// model predicts dq_oe, wait_out, protocol_err and dq_out for every cycle.
`timescale 1ns/1ps
module tb_cram_responder;

  localparam int ADDR_W = 12;
  localparam int RD_LAT = 3;
  localparam int MAXC   = 20000;
`ifdef CRAM_RESPONDER_BCR_EN
  localparam logic [15:0] BCR_EXP = 16'h2800;
  localparam int          BCR_LAT = 5;
`else
  localparam logic [15:0] BCR_EXP = 16'h0000;
  localparam int          BCR_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic [5:0]  a;
  logic        adv_n, cre, ce0_n, ce1_n, oe_n, we_n, ub_n, lb_n;
  logic        wait_out, protocol_err;
  logic [15:0] bcr;

  cram_responder #(.ADDR_W(ADDR_W), .READ_LATENCY(RD_LAT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dq_in        (dq_in),
    .dq_out       (dq_out),
    .dq_oe        (dq_oe),
    .a            (a),
    .adv_n        (adv_n),
    .cre          (cre),
    .ce0_n        (ce0_n),
    .ce1_n        (ce1_n),
    .oe_n         (oe_n),
    .we_n         (we_n),
    .ub_n         (ub_n),
    .lb_n         (lb_n),
    .wait_out     (wait_out),
    .protocol_err (protocol_err),
    .bcr          (bcr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mdl_mem [2][2**ADDR_W];
  logic [15:0] mdl_bcr = 16'h0000;
  bit          exp_oe   [MAXC];
  bit          exp_wait [MAXC];
  bit          exp_perr [MAXC];
  logic [15:0] exp_dq   [MAXC];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [15:0] rd;
  int          lat, wc;
  logic [21:0] pool [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  function automatic int mdl_lat();
    return (mdl_bcr[13:11] != 3'd0) ? int'(mdl_bcr[13:11]) : RD_LAT;
  endfunction

  // Outputs after posedge number cyc are compared on the following negedge.
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      check($sformatf("dq_oe@%0d", cyc), 32'(dq_oe), 32'(exp_oe[cyc]));
      check($sformatf("wait_out@%0d", cyc), 32'(wait_out), 32'(exp_wait[cyc]));
      check($sformatf("protocol_err@%0d", cyc), 32'(protocol_err), 32'(exp_perr[cyc]));
      if (exp_oe[cyc]) check($sformatf("dq_out@%0d", cyc), 32'(dq_out), 32'(exp_dq[cyc]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    ce0_n = 1'b1; ce1_n = 1'b1; adv_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
    cre = 1'b0; ub_n = 1'b1; lb_n = 1'b1;
    dq_in = 16'($urandom); a = 6'($urandom);
  endtask

  task automatic addr_phase(input int die, input logic [21:0] addr);
    if (die == 1) ce1_n = 1'b0; else ce0_n = 1'b0;
    adv_n = 1'b0; a = addr[21:16]; dq_in = addr[15:0];
    step();
    adv_n = 1'b1;
  endtask

  task automatic read_word(input int die, input logic [21:0] addr, input int nrd,
                           output logic [15:0] rdv, output int latv, output int wcnt);
    int L, N;
    rdv = '0; latv = -1; wcnt = 0;
    addr_phase(die, addr);
    for (int r = 0; r < nrd; r++) begin
      L = mdl_lat();
      N = cyc + 1;
      for (int i = 0; i < L; i++) exp_wait[N+i] = 1'b1;
      for (int i = 0; i < 2; i++) begin
        exp_oe[N+L+i] = 1'b1;
        exp_dq[N+L+i] = mdl_mem[die][addr[ADDR_W-1:0]];
      end
      oe_n = 1'b0; dq_in = 16'($urandom);
      latv = -1; wcnt = 0;
      for (int k = 0; k < L + 2; k++) begin
        step();
        if (wait_out) wcnt++;
        if (dq_oe && latv < 0) begin
          latv = k;
          rdv  = dq_out;
        end
      end
      oe_n = 1'b1;
      step();
    end
    idle_bus();
    step();
  endtask

  task automatic write_word(input int die, input logic [21:0] addr, input logic [15:0] data,
                            input logic ub, input logic lb, input logic docre, input int ncap);
    addr_phase(die, addr);
    we_n = 1'b0;
    for (int c = 0; c < ncap; c++) begin
      if (c == ncap - 1) begin
        dq_in = data; ub_n = ub; lb_n = lb;
      end else begin
        dq_in = 16'($urandom); ub_n = 1'($urandom); lb_n = 1'($urandom);
      end
      step();
    end
    we_n = 1'b1; cre = docre;
    if (docre) begin
`ifdef CRAM_RESPONDER_BCR_EN
      mdl_bcr = addr[15:0];
`else
      exp_perr[cyc+1] = 1'b1;
`endif
    end else begin
      if (!ub) mdl_mem[die][addr[ADDR_W-1:0]][15:8] = data[15:8];
      if (!lb) mdl_mem[die][addr[ADDR_W-1:0]][7:0]  = data[7:0];
    end
    step();
    idle_bus();
    step();
  endtask

  initial begin
    #(MAXC * 10);
    $display("[TB] FAIL watchdog: simulation did not finish within %0d cycles", MAXC);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d, p, L;
    reset_n = 1'b0;
    idle_bus();
    step(); step();
    check("reset_dq_oe", 32'(dq_oe), 32'd0);
    check("reset_wait", 32'(wait_out), 32'd0);
    check("reset_perr", 32'(protocol_err), 32'd0);
    check("reset_bcr", 32'(bcr), 32'h0000);
    check("reset_dq_out", 32'(dq_out), 32'h0000);
    reset_n = 1'b1;
    step();

    // Basic write then read with default latency.
    write_word(0, 22'h000123, 16'hA55A, 1'b0, 1'b0, 1'b0, 1);
    read_word(0, 22'h000123, 1, rd, lat, wc);
    check("rd_a55a", 32'(rd), 32'h0000A55A);
    check("lat_default", 32'(lat), 32'd3);
    check("wait_cycles", 32'(wc), 32'd3);

    // Byte masking, die isolation, address aliasing.
    write_word(0, 22'h000010, 16'h1234, 1'b0, 1'b0, 1'b0, 1);
    write_word(0, 22'h000010, 16'hFFFF, 1'b1, 1'b0, 1'b0, 2);
    read_word(0, 22'h000010, 1, rd, lat, wc);
    check("rd_12ff", 32'(rd), 32'h000012FF);
    write_word(1, 22'h000010, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1);
    read_word(0, 22'h000010, 1, rd, lat, wc);
    check("die0_unchanged", 32'(rd), 32'h000012FF);
    read_word(1, 22'h000010, 2, rd, lat, wc);
    check("die1_beef", 32'(rd), 32'h0000BEEF);
    read_word(1, 22'h001010, 1, rd, lat, wc);
    check("alias_beef", 32'(rd), 32'h0000BEEF);

    // Both CEs low in IDLE.
    ce0_n = 1'b0; ce1_n = 1'b0;
    exp_perr[cyc+1] = 1'b1;
    step();
    idle_bus();
    step();

    // OE# and WE# low together from ADDR, then from WRITE.
    addr_phase(0, 22'h000010);
    oe_n = 1'b0; we_n = 1'b0; dq_in = 16'h0000;
    exp_perr[cyc+1] = 1'b1;
    step();
    oe_n = 1'b1; we_n = 1'b1;
    step();
    idle_bus();
    step();
    addr_phase(0, 22'h000010);
    we_n = 1'b0; dq_in = 16'h0000; ub_n = 1'b0; lb_n = 1'b0;
    step();
    oe_n = 1'b0;
    exp_perr[cyc+1] = 1'b1;
    step();
    oe_n = 1'b1; we_n = 1'b1;
    step();
    idle_bus();
    step();

    // CE# rising mid-write discards the write.
    addr_phase(0, 22'h000010);
    we_n = 1'b0; dq_in = 16'h0000; ub_n = 1'b0; lb_n = 1'b0;
    step();
    ce0_n = 1'b1;
    step();
    we_n = 1'b1;
    step();
    idle_bus();
    step();
    read_word(0, 22'h000010, 1, rd, lat, wc);
    check("no_write_after_errors", 32'(rd), 32'h000012FF);

    // Configuration register write.
    write_word(0, 22'h002800, 16'h5555, 1'b0, 1'b0, 1'b1, 1);
    check("bcr_value", 32'(bcr), 32'(BCR_EXP));
    check("model_lat", 32'(mdl_lat()), 32'(BCR_LAT));
    read_word(0, 22'h000123, 1, rd, lat, wc);
    check("lat_after_bcr", 32'(lat), 32'(BCR_LAT));
    check("rd_after_bcr", 32'(rd), 32'h0000A55A);

    // Randomized traffic over a small address pool (entry 7 aliases entry 0).
    for (int i = 0; i < 7; i++) pool[i] = 22'($urandom);
    pool[7] = pool[0] ^ 22'h001000;
    for (int i = 0; i < 7; i++) begin
      write_word(0, pool[i], 16'($urandom), 1'b0, 1'b0, 1'b0, 1);
      write_word(1, pool[i], 16'($urandom), 1'b0, 1'b0, 1'b0, 1);
    end
    for (int t = 0; t < 60; t++) begin
      d = int'($urandom_range(0, 1));
      p = int'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0)
        read_word(d, pool[p], int'($urandom_range(1, 2)), rd, lat, wc);
      else
        write_word(d, pool[p], 16'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                   int'($urandom_range(1, 3)));
    end
    for (int i = 0; i < 8; i++) begin
      read_word(0, pool[i], 1, rd, lat, wc);
      read_word(1, pool[i], 1, rd, lat, wc);
    end

    // Asynchronous reset while driving read data.
    addr_phase(0, 22'h000123);
    L = mdl_lat();
    for (int i = 0; i < L; i++) exp_wait[cyc+1+i] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_oe[cyc+1+L+i] = 1'b1;
      exp_dq[cyc+1+L+i] = 16'hA55A;
    end
    oe_n = 1'b0;
    for (int k = 0; k < L + 1; k++) step();
    check("pre_reset_oe", 32'(dq_oe), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_dq_oe", 32'(dq_oe), 32'd0);
    check("async_rst_wait", 32'(wait_out), 32'd0);
    check("async_rst_bcr", 32'(bcr), 32'h0000);
    for (int i = cyc; i < cyc + 50; i++) begin
      exp_oe[i] = 1'b0; exp_wait[i] = 1'b0; exp_perr[i] = 1'b0;
    end
    mdl_bcr = 16'h0000;
    idle_bus();
    step(); step();
    reset_n = 1'b1;
    step();
    read_word(0, 22'h000123, 1, rd, lat, wc);
    check("rd_after_reset", 32'(rd), 32'h0000A55A);
    check("lat_after_reset", 32'(lat), 32'd3);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cram_responder.md
# cram_responder

Synthesizable device-side model of the Pocket cellular RAM (two dies, asynchronous mode, address/data multiplexed on DQ). It sits on the far end of the CRAM pins in simulation and FPGA loopback benches. It answers controller-generated bus cycles: it latches addresses, performs byte-masked writes into internal storage and drives read data after a programmable latency. The controller under test talks to it exactly as it would to the real part.

## Interface
Parameters:
- ADDR_W, 12: stored word-address bits per die; higher address bits alias.
- READ_LATENCY, 3: clk cycles from OE# sampled low to DQ driven; must be 1..7.

Ports:
- clk  input  1  single clock; every bus input is sampled on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- dq_in  input  16  DQ value driven by the controller.
- dq_out  output  16  read data toward the controller.
- dq_oe  output  1  1 = responder drives DQ.
- a  input  6  address bits [21:16].
- adv_n, cre, ce0_n, ce1_n, oe_n, we_n, ub_n, lb_n  input  1 each  standard CRAM strobes, active-low except cre.
- wait_out  output  1  1 while read data is not yet valid.
- protocol_err  output  1  one-cycle pulse on an illegal strobe combination.
- bcr  output  16  current bus configuration register.

## Operation
- Die select: die 0 when ce0_n=0, die 1 when ce1_n=0. If both are low, protocol_err pulses and the FSM returns to IDLE.
- FSM states: IDLE, ADDR, READ_WAIT, READ_DRIVE, WRITE.
- IDLE → ADDR when a die is selected and adv_n=0. While adv_n=0, addr = {a, dq_in} is captured every cycle, so the last low sample wins.
- ADDR → READ_WAIT when oe_n=0 and we_n=1. The latency counter loads the effective latency and wait_out=1.
- READ_WAIT → READ_DRIVE when the counter reaches 0. dq_oe=1, wait_out=0, dq_out = mem[die][addr].
- READ_DRIVE holds while oe_n=0 and re-reads every cycle, with no auto-increment.
- READ_DRIVE → ADDR when oe_n=1, so a new read can start without a new ADV#.
- ADDR → WRITE when we_n=0 and oe_n=1. Each cycle in WRITE captures dq_in, ub_n and lb_n.
- WRITE → ADDR on we_n rising. The last captured sample is committed: ub_n=0 writes [15:8], lb_n=0 writes [7:0], and if both are high nothing is written.
- If cre=1 at the we_n rising edge, the write goes to the BCR instead of the array (see Configuration).
- oe_n=0 and we_n=0 sampled together in any state except IDLE: protocol_err pulses, the state goes to ADDR and nothing is written.
- The selected CE# rising in any state aborts to IDLE, and any pending write is discarded.
- A new adv_n=0 in ADDR or READ_DRIVE re-latches the address.
- Storage is not cleared by reset.

## Timing
- Reset values: dq_oe=0, dq_out=0, wait_out=0, protocol_err=0, bcr=16'h0000, state IDLE.
- Read latency: oe_n sampled low on edge N gives dq_oe=1 and valid dq_out after edge N+L, where L is the effective latency.
- dq_oe falls on the edge after oe_n or CE# is sampled high.
- A write commits on the edge where we_n is sampled high. Read-after-write returns the new data with no bypass penalty.
- reset_n asserted mid-cycle forces the reset values immediately (asynchronous reset).

## Configuration
- CRAM_RESPONDER_BCR_EN defined:
  - cre=1 at the write commit loads bcr = addr[15:0].
  - Effective latency = bcr[13:11] if nonzero, else READ_LATENCY.
- Macro undefined:
  - cre=1 write commits are dropped and pulse protocol_err.
  - bcr is tied to 0 and the effective latency is always READ_LATENCY.

## Structure
- Package pocket gains:
  - cram_resp_state_e, the FSM enum.
  - CRAM_BCR_LAT_LSB=11 and CRAM_BCR_LAT_W=3.
- Sub-module cram_responder_mem: one instance per die, a single-port RAM of 2**ADDR_W x 16 with two byte-enables and an asynchronous read port.

## Test plan
- Write 16'hA55A to die 0 at addr 22'h000123 with ub_n=lb_n=0, then read it back → dq_oe rises exactly 3 cycles after OE# low, dq_out=16'hA55A, wait_out=1 for 3 cycles.
- Die 0 word 22'h10 holds 16'h1234; write 16'hFFFF with ub_n=1, lb_n=0 → reading 22'h10 returns 16'h12FF.
- Write 16'hBEEF to die 1 at 22'h10 → die 0 22'h10 is unchanged and die 1 returns 16'hBEEF. With ADDR_W=12, address 22'h001010 aliases 22'h10 and also returns 16'hBEEF on die 1.
- ce0_n=ce1_n=0 sampled together, or oe_n=we_n=0 sampled together → protocol_err high for exactly 1 cycle and no memory change. Raising CE# mid-write discards the write.
- With CRAM_RESPONDER_BCR_EN, a cre=1 write with addr[15:0]=16'h2800 → bcr=16'h2800 and the next read has dq_oe after 5 cycles. Without the macro: bcr=0, protocol_err pulses and latency stays 3.
- Assert reset_n during READ_DRIVE → dq_oe=0 and wait_out=0 immediately; a read after reset returns the previously written data.
